// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: request/response bundle between the execute stage and the
// multiply/divide controller.
//   start   request valid (held by the pipeline while stall is high)
//   op      0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6/7=no request
//   rs_val  operand A (dividend, multiplicand, MTHI/MTLO source)
//   rt_val  operand B (divisor, multiplier)
//   mf_req  execute stage holds an MFHI/MFLO this cycle
//   busy    operation in flight
//   stall   hold the pipeline (busy and a request that needs HI/LO)
//   done    one-cycle pulse after MULT/DIV results land in HI/LO
//   hi, lo  HI/LO registers
// master = pipeline side, slave = controller side.
interface mdu_ctrl_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        mf_req;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, rs_val, rt_val, mf_req,
      input  busy, stall, done, hi, lo
   );

   modport slave (
      input  start, op, rs_val, rt_val, mf_req,
      output busy, stall, done, hi, lo
   );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide controller owning the HI/LO registers.
// Two-cycle multiply, 32-step restoring divide plus a sign-fix cycle, and
// single-cycle MTHI/MTLO. Stalls the pipeline while an operation is in flight.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    mdu_ctrl_if.slave (start/op/rs_val/rt_val/mf_req in,
//          busy/stall/done/hi/lo out)
module mdu_ctrl (
   input logic       clk,
   input logic       reset,
   mdu_ctrl_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

   localparam logic [2:0] OpMult  = 3'd0;
   localparam logic [2:0] OpMultu = 3'd1;
   localparam logic [2:0] OpDiv   = 3'd2;
   localparam logic [2:0] OpDivu  = 3'd3;
   localparam logic [2:0] OpMthi  = 3'd4;
   localparam logic [2:0] OpMtlo  = 3'd5;

   state_e state_q, state_d;

   logic [31:0] hi_q, lo_q;
   logic [31:0] a_q;          // raw operand A (multiplicand, or HI on divide-by-zero)
   logic [31:0] b_q;          // multiplier, or divisor magnitude
   logic [31:0] quo_q;        // dividend bits shifting out, quotient bits shifting in
   logic [31:0] rem_q;        // partial remainder, always below the divisor
   logic [5:0]  cnt_q;
   logic        mul_signed_q;
   logic        sign_q_q;
   logic        sign_r_q;
   logic        dz_q;
   logic        done_q;

   // Control decoded from state
   logic busy;
   logic op_mul, op_div;
   logic mthi_we, mtlo_we;
   logic mul_start, div_start;
   logic mul_we, div_step, fix_we;

   // Datapath combinational signals
   logic        div_signed;
   logic [31:0] rs_mag, rt_mag;
   logic [63:0] mul_a, mul_b, prod;
   logic [32:0] rem_sh, trial;
   logic [31:0] rem_n, quo_n;
   logic [31:0] fix_hi, fix_lo;

   assign op_mul = (bus.op == OpMult) || (bus.op == OpMultu);
   assign op_div = (bus.op == OpDiv) || (bus.op == OpDivu);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               if (op_mul) begin
                  state_d = StMul;
               end else if (op_div) begin
                  // A zero divisor skips the iterations; FIX supplies fixed results.
                  state_d = (bus.rt_val == 32'd0) ? StFix : StDiv;
               end
            end
         end
         StMul:   state_d = StIdle;
         StDiv:   if (cnt_q == 6'd31) state_d = StFix;
         StFix:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      mthi_we   = 1'b0;
      mtlo_we   = 1'b0;
      mul_start = 1'b0;
      div_start = 1'b0;
      mul_we    = 1'b0;
      div_step  = 1'b0;
      fix_we    = 1'b0;
      unique case (state_q)
         StIdle: begin
            mthi_we   = bus.start && (bus.op == OpMthi);
            mtlo_we   = bus.start && (bus.op == OpMtlo);
            mul_start = bus.start && op_mul;
            div_start = bus.start && op_div;
         end
         StMul: begin
            busy   = 1'b1;
            mul_we = 1'b1;
         end
         StDiv: begin
            busy     = 1'b1;
            div_step = 1'b1;
         end
         StFix: begin
            busy   = 1'b1;
            fix_we = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.busy  = busy;
   // Combinational so it drops in the same cycle the FSM returns to IDLE.
   assign bus.stall = busy & (bus.start | bus.mf_req);
   assign bus.done  = done_q;
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;

   // ---------------------------------------------------------- datapath
   always_comb begin
      div_signed = (bus.op == OpDiv);
      rs_mag = (div_signed && bus.rs_val[31]) ? -bus.rs_val : bus.rs_val;
      rt_mag = (div_signed && bus.rt_val[31]) ? -bus.rt_val : bus.rt_val;
   end

   // Extending both operands to 64 bits makes the low 64 product bits correct
   // for signed and unsigned alike.
   always_comb begin
      mul_a = mul_signed_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
      mul_b = mul_signed_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
      prod  = mul_a * mul_b;
   end

   // Restoring step. rem_q < divisor, so the shifted value is below twice the
   // divisor and bit 32 of the 33-bit difference is a reliable sign.
   always_comb begin
      rem_sh = {rem_q, quo_q[31]};
      trial  = rem_sh - {1'b0, b_q};
      rem_n  = trial[32] ? rem_sh[31:0] : trial[31:0];
      quo_n  = {quo_q[30:0], ~trial[32]};
   end

   // 0x80000000 / -1 needs no special case: magnitudes give q=0x80000000 with
   // a positive sign, which is the required wrapped result.
   always_comb begin
      if (dz_q) begin
         fix_lo = 32'hFFFF_FFFF;
         fix_hi = a_q;
      end else begin
         fix_lo = sign_q_q ? -quo_q : quo_q;
         fix_hi = sign_r_q ? -rem_q : rem_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi_q         <= 32'd0;
         lo_q         <= 32'd0;
         a_q          <= 32'd0;
         b_q          <= 32'd0;
         quo_q        <= 32'd0;
         rem_q        <= 32'd0;
         cnt_q        <= 6'd0;
         mul_signed_q <= 1'b0;
         sign_q_q     <= 1'b0;
         sign_r_q     <= 1'b0;
         dz_q         <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= mul_we | fix_we;

         if (mthi_we) hi_q <= bus.rs_val;
         if (mtlo_we) lo_q <= bus.rs_val;
         if (mul_we) begin
            hi_q <= prod[63:32];
            lo_q <= prod[31:0];
         end
         if (fix_we) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
         end

         if (mul_start || div_start) begin
            a_q          <= bus.rs_val;
            mul_signed_q <= (bus.op == OpMult);
         end
         if (mul_start) begin
            b_q <= bus.rt_val;
         end
         if (div_start) begin
            b_q      <= rt_mag;
            quo_q    <= rs_mag;
            rem_q    <= 32'd0;
            cnt_q    <= 6'd0;
            sign_q_q <= div_signed & (bus.rs_val[31] ^ bus.rt_val[31]);
            sign_r_q <= div_signed & bus.rs_val[31];
            dz_q     <= (bus.rt_val == 32'd0);
         end
         if (div_step) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q + 6'd1;
         end
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and randomized bench for mdu_ctrl with a
// transaction-level reference model of HI/LO, busy duration and done timing.
module tb_mdu_ctrl;

   logic clk;
   logic reset;

   mdu_ctrl_if bus ();

   mdu_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;
   int busy_cnt = 0;
   bit rand_mf = 1'b0;

   // Reference model: results computed with plain arithmetic at acceptance,
   // committed after the busy time the operation is allowed.
   int              m_left = 0;
   logic [31:0]     m_hi = '0;
   logic [31:0]     m_lo = '0;
   logic            m_done = 1'b0;
   logic [31:0]     p_hi, p_lo;
   longint unsigned pa, pb, prod;
   longint          sa, sb, sq, sr;
   logic [31:0]     uq, ur;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_hi   = '0;
         m_lo   = '0;
         m_left = 0;
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_hi   = p_hi;
               m_lo   = p_lo;
               m_done = 1'b1;
            end
         end else if (bus.start) begin
            case (bus.op)
               3'd4: m_hi = bus.rs_val;
               3'd5: m_lo = bus.rs_val;
               3'd0, 3'd1: begin
                  if (bus.op == 3'd0) begin
                     pa = {{32{bus.rs_val[31]}}, bus.rs_val};
                     pb = {{32{bus.rt_val[31]}}, bus.rt_val};
                  end else begin
                     pa = {32'd0, bus.rs_val};
                     pb = {32'd0, bus.rt_val};
                  end
                  prod   = pa * pb;
                  p_hi   = prod[63:32];
                  p_lo   = prod[31:0];
                  m_left = 1;
               end
               3'd2, 3'd3: begin
                  if (bus.rt_val == 32'd0) begin
                     p_hi   = bus.rs_val;
                     p_lo   = 32'hFFFF_FFFF;
                     m_left = 1;
                  end else begin
                     if (bus.op == 3'd2) begin
                        sa   = $signed({{32{bus.rs_val[31]}}, bus.rs_val});
                        sb   = $signed({{32{bus.rt_val[31]}}, bus.rt_val});
                        sq   = sa / sb;
                        sr   = sa % sb;
                        p_lo = sq[31:0];
                        p_hi = sr[31:0];
                     end else begin
                        uq   = bus.rs_val / bus.rt_val;
                        ur   = bus.rs_val % bus.rt_val;
                        p_lo = uq;
                        p_hi = ur;
                     end
                     m_left = 33;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Per-cycle compare, away from the active edge.
   always @(negedge clk) begin
      if (bus.busy) busy_cnt++;
      check("busy", 32'(bus.busy), 32'(m_left != 0));
      check("stall", 32'(bus.stall), 32'((m_left != 0) && (bus.start || bus.mf_req)));
      check("done", 32'(bus.done), 32'(m_done));
      check("hi", bus.hi, m_hi);
      check("lo", bus.lo, m_lo);
   end

   // Random MFHI/MFLO traffic when enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_mf) bus.mf_req = 1'($urandom_range(0, 1));
      end
   end

   // Hold the request until the first edge the model says is IDLE.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      bit accepted;
      bus.start  = 1'b1;
      bus.op     = o;
      bus.rs_val = a;
      bus.rt_val = b;
      for (int i = 0; i < 100; i++) begin
         accepted = (m_left == 0);
         @(posedge clk);
         #1;
         if (accepted) break;
      end
      bus.start  = 1'b0;
      bus.op     = 3'($urandom);
      bus.rs_val = $urandom;
      bus.rt_val = $urandom;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         if (m_left == 0) break;
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 6))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 15));
         5:       return -32'($urandom_range(1, 15));
         default: return $urandom;
      endcase
   endfunction

   logic [31:0] save_hi, save_lo;

   initial begin
      reset      = 1'b0;
      bus.start  = 1'b0;
      bus.op     = 3'd0;
      bus.rs_val = '0;
      bus.rt_val = '0;
      bus.mf_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_hi", bus.hi, 32'd0);
      check("rst_lo", bus.lo, 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // MTLO / MTHI: visible next cycle, never busy
      issue(3'd5, 32'hDEAD_BEEF, 32'd0);
      check("mtlo_lo", bus.lo, 32'hDEAD_BEEF);
      check("mtlo_busy", 32'(bus.busy), 32'd0);
      issue(3'd4, 32'h1357_9BDF, 32'd0);
      check("mthi_hi", bus.hi, 32'h1357_9BDF);
      check("mthi_done", 32'(bus.done), 32'd0);

      // op 6/7: no effect
      save_hi = bus.hi;
      save_lo = bus.lo;
      issue(3'd6, 32'h1111_1111, 32'h2);
      issue(3'd7, 32'h2222_2222, 32'h3);
      check("op67_hi", bus.hi, save_hi);
      check("op67_lo", bus.lo, save_lo);
      check("op67_busy", 32'(bus.busy), 32'd0);

      // MULT / MULTU
      busy_cnt = 0;
      issue(3'd0, 32'hFFFF_FFFE, 32'd3);
      wait_idle();
      check("mult_hi", bus.hi, 32'hFFFF_FFFF);
      check("mult_lo", bus.lo, 32'hFFFF_FFFA);
      check("mult_busy_cycles", 32'(busy_cnt), 32'd1);
      check("mult_done", 32'(bus.done), 32'd1);
      issue(3'd1, 32'hFFFF_FFFE, 32'd3);
      wait_idle();
      check("multu_hi", bus.hi, 32'h0000_0002);
      check("multu_lo", bus.lo, 32'hFFFF_FFFA);

      // Signed divides
      busy_cnt = 0;
      issue(3'd2, 32'hFFFF_FFF9, 32'd2);
      wait_idle();
      check("div_m7_2_lo", bus.lo, 32'hFFFF_FFFD);
      check("div_m7_2_hi", bus.hi, 32'hFFFF_FFFF);
      check("div_busy_cycles", 32'(busy_cnt), 32'd33);
      issue(3'd2, 32'd7, 32'hFFFF_FFFE);
      wait_idle();
      check("div_7_m2_lo", bus.lo, 32'hFFFF_FFFD);
      check("div_7_m2_hi", bus.hi, 32'd1);
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle();
      check("div_ovf_lo", bus.lo, 32'h8000_0000);
      check("div_ovf_hi", bus.hi, 32'd0);

      // Divide by zero
      busy_cnt = 0;
      issue(3'd3, 32'h0000_1234, 32'd0);
      wait_idle();
      check("dz_hi", bus.hi, 32'h0000_1234);
      check("dz_lo", bus.lo, 32'hFFFF_FFFF);
      check("dz_busy_cycles", 32'(busy_cnt), 32'd1);
      check("dz_done", 32'(bus.done), 32'd1);

      // Reset during divide iteration 10
      issue(3'd3, 32'd500, 32'd3);
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      #1;
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_hi", bus.hi, 32'd0);
      check("midrst_lo", bus.lo, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      busy_cnt = 0;
      issue(3'd3, 32'd100, 32'd7);
      wait_idle();
      check("divu_100_7_lo", bus.lo, 32'd14);
      check("divu_100_7_hi", bus.hi, 32'd2);
      check("divu_busy_cycles", 32'(busy_cnt), 32'd33);

      // Back-to-back with mf_req held: second start waits for the first IDLE edge
      bus.mf_req = 1'b1;
      busy_cnt = 0;
      issue(3'd2, 32'd1000, 32'd7);
      issue(3'd1, 32'd5, 32'd6);
      check("b2b_div_lo", bus.lo, 32'd142);
      check("b2b_div_hi", bus.hi, 32'd6);
      check("b2b_mul_busy", 32'(bus.busy), 32'd1);
      wait_idle();
      check("b2b_mul_lo", bus.lo, 32'd30);
      check("b2b_mul_hi", bus.hi, 32'd0);
      check("b2b_busy_cycles", 32'(busy_cnt), 32'd34);
      bus.mf_req = 1'b0;

      // Randomized traffic
      rand_mf = 1'b1;
      for (int t = 0; t < 200; t++) begin
         issue(3'($urandom_range(0, 7)), rnd_val(), rnd_val());
         if ($urandom_range(0, 2) == 0) begin
            wait_idle();
         end else begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
         end
      end
      wait_idle();
      rand_mf = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the MIPS core. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the execute stage and owns the HI/LO registers. It sequences a 32-iteration restoring divider and a two-cycle multiply, and asserts a stall to the pipeline while an operation is in flight. MFHI/MFLO read HI/LO directly from this block.

## Interface
- No parameters; datapath width is fixed at 32.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request valid for one cycle; accepted only in IDLE.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=ignored (treated as no request).
- rs_val  in  32  operand A (dividend, multiplicand, MTHI/MTLO source).
- rt_val  in  32  operand B (divisor, multiplier).
- mf_req  in  1  execute stage holds an MFHI/MFLO this cycle.
- busy  out  1  high while state is not IDLE.
- stall  out  1  combinational: busy & (start | mf_req).
- done  out  1  one-cycle pulse on the cycle after HI/LO are written by MULT/DIV.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE, start, op 4/5: write rs_val to HI (op 4) or LO (op 5) at that edge. Stay in IDLE. No done pulse.
- IDLE, start, op 0/1: latch operands and go to MUL.
  - MUL: compute the 64-bit product, signed for op 0, unsigned for op 1.
  - Write HI=product[63:32] and LO=product[31:0], then go to IDLE.
- IDLE, start, op 2/3: latch operands and go to DIV.
  - Signed (op 2): take magnitudes of both operands; record sign_q = a[31]^b[31] and sign_r = a[31].
  - Unsigned (op 3): use operands as-is; both sign flags 0.
  - Divisor zero: go to FIX directly.
  - Otherwise: clear the 6-bit iteration counter and go to DIV.
- DIV: one restoring step per cycle over a 33-bit partial remainder.
  - Shift in the next dividend MSB, then trial-subtract the divisor.
  - Set the quotient bit if the result is non-negative, and restore the remainder if not.
  - After 32 steps (counter==31), go to FIX.
- FIX: apply signs. LO = sign_q ? -q : q; HI = sign_r ? -r : r. Write HI/LO, then go to IDLE.
  - Divide by zero: HI = rs_val as latched, LO = 32'hFFFFFFFF (signed and unsigned alike).
  - Signed overflow (0x80000000 / -1): LO=0x80000000, HI=0. This falls out of magnitude arithmetic; no special case.
- start while busy: not accepted. stall is asserted; the pipeline holds start/op/operands until IDLE.
- mf_req while busy: stall asserted. In IDLE, hi/lo are already final, so no stall.
- Reset (any time, including mid-divide): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Partial results are discarded.

## Timing
- Edge E0 accepts start.
- MTHI/MTLO: register updated at E0; visible on hi/lo the cycle after E0; latency 1, no busy.
- MULT/MULTU:
  - busy high for 1 cycle (after E0).
  - HI/LO written at E1 and valid from the cycle after E1.
  - done high during that cycle.
- DIV/DIVU, nonzero divisor:
  - busy high for 33 cycles: 32 DIV + 1 FIX.
  - HI/LO written at E33; done pulses the cycle after E33.
- DIV/DIVU, zero divisor:
  - busy high for 1 cycle (FIX).
  - HI/LO written at E1; done pulses the cycle after E1.
- Back-to-back: a new start may be accepted on the first edge where the state is IDLE, which is the same cycle done is high.
- stall has no registered delay. It must drop in the same cycle busy drops.

## Test plan
- Reset mid-DIV: assert reset low during DIV iteration 10 → hi=lo=0, busy=0, state IDLE immediately. Then DIVU 100/7 → LO=14, HI=2 after 33 busy cycles.
- MULT rs=0xFFFFFFFE (-2), rt=3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA after 1 busy cycle. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV signed -7/2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Also 7/-2 → LO=-3, HI=1. Also 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: DIVU 0x1234/0 → HI=0x1234, LO=0xFFFFFFFF, busy for exactly 1 cycle, done pulse.
- Hazards:
  - mf_req and start asserted during DIV → stall=1 every busy cycle and 0 in the done cycle.
  - A second start held through the busy window → accepted exactly at the first IDLE edge.
  - MTLO 0xDEADBEEF in IDLE → lo updates next cycle, busy stays 0.
- op 6/7 with start in IDLE → no state change; hi/lo unchanged.
